axi3_mas_port: RTL and testbench
================================

// Module: axi3_mas_port
// PURPOSE
// AXI3 master-side port engine: converts a simple command/data request interface into
// fully compliant AXI3 write (AW/W/B) and read (AR/R) channel traffic. Sits between
// an agent/driver core and the AXI3 bus. All AXI outputs clear asynchronously on reset.
// Write and read paths are independent and may be active concurrently; one outstanding burst each.
// PARAMETERS
// ID_W    4   width of awid/wid/bid/arid/rid and cmd_id
// ADDR_W  32  width of awaddr/araddr/cmd_addr
// DATA_W  32  width of wdata/rdata; STRB_W = DATA_W/8 (derived, not overridable)
// PORTS
// aclk                           in   1       clock, all state on rising edge
// arstn                          in   1       async active-low reset
// cmd_valid/cmd_ready            in/out 1/1   command handshake
// cmd_write                      in   1       1=write burst, 0=read burst
// cmd_id/cmd_addr                in   ID_W/ADDR_W  burst ID, start address
// cmd_len/cmd_size/cmd_burst     in   4/3/2   AXI3 len (beats-1), size, burst type
// wd_valid/wd_ready              in/out 1/1   write-beat handshake
// wd_data/wd_strb                in   DATA_W/STRB_W  write beat payload
// wr_done/wr_id/wr_resp          out  1/ID_W/2  1-cycle pulse on B completion
// rd_valid/rd_data/rd_resp/rd_last/rd_id out 1/DATA_W/2/1/ID_W  read beat, 1-cycle per beat
// awid,awaddr,awlen,awsize,awbrust,awlock,awcache,awprot,awvalid out; awready in
// wid,wdata,wstrob,wlast,wvalid out; wready in
// bid,bresp,bvalid in; bready out
// arid,araddr,arlen,arsize,arbrust,arlock,arcache,arprot,arvalid out; arready in
// rid,rdata,rresp,rlast,rvalid in; rready out
// (AXI widths: id ID_W, addr ADDR_W, len 4, size 3, brust 2, lock 2, cache 4, prot 3, data DATA_W, strob STRB_W, resp 2)
// BEHAVIOUR
// - Reset (arstn=0, async): every output incl. all AXI outputs, cmd_ready, wd_ready, pulses = 0;
//   both FSMs to IDLE. Reset mid-burst abandons burst; no completion reported.
// - awlock/arlock=2'b00, awcache/arcache=4'b0000, awprot/arprot=3'b000 always.
// - cmd_ready = (cmd_write ? W_IDLE : R_IDLE), combinational from state; accept on cmd_valid&cmd_ready.
// - Write FSM: W_IDLE -> W_ADDR (next cycle awvalid=1, aw* registered from cmd) ->
//   on awvalid&awready -> W_DATA; awvalid drops next edge.
//   W_DATA: wd_ready=~wvalid|wready; beat loads wdata/wstrob, wid=burst id,
//   wvalid=1, wlast=1 on beat index==len; beat completes on wvalid&wready.
//   After last beat completes -> W_RESP: bready=1; on bvalid -> wr_done pulse,
//   wr_id=bid, wr_resp=bresp, -> W_IDLE. No AW/W overlap (W only after AW accepted).
// - Read FSM: R_IDLE -> R_ADDR (arvalid=1, ar* registered) -> on arready -> R_DATA:
//   rready=1; each rvalid beat forwarded next cycle on rd_* (rd_valid pulse);
//   on rvalid&rlast -> R_IDLE, rready=0. Beat count not checked against len.
// - valid/payload held stable until ready; no valid drops without handshake.
// - Zero-wait ready (ready high same cycle as valid) gives 1 beat/cycle throughput on W and R.
// - Simultaneous write and read commands: only the one selected by cmd_write is accepted.
// - Burst type/size passed through unchecked; len=0 gives single beat with wlast=1.
// TESTING
// - Reset: drive arstn=0 mid W_DATA -> all AXI outputs 0 immediately, FSMs IDLE, no wr_done.
// - Write len=3 id=5 addr=0x1000, awready after 2 cycles, wready=1 -> 4 W beats, wid=5,
//   wlast only on 4th; bvalid bresp=0 bid=5 -> wr_done pulse, wr_resp=0, wr_id=5.
// - Write len=0 with wready toggling 0/1 -> wdata/wstrob stable while wvalid&~wready; wlast=1.
// - Read len=7 id=3 addr=0x2000 -> arvalid until arready; 8 rvalid beats data 0..7, rlast on 8th
//   -> 8 rd_valid pulses, rd_last on last, rd_id=3; rready drops after.
// - Concurrent write (len=1) and read (len=1) -> both complete, channels independent.
// - Fixed signals: any burst -> awlock/arlock=0, cache=0, prot=0.

Source files
------------

// File: rtl/axi3_mas_port.sv
// rtl/axi3_mas_port.sv - AXI3 master port engine: command/data requests to AW/W/B and AR/R traffic
// Independent write and read FSMs, one outstanding burst each.
module axi3_mas_port #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              i_aclk,
  input  logic              i_arstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ID_W-1:0]   i_cmd_id,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [3:0]        i_cmd_len,
  input  logic [2:0]        i_cmd_size,
  input  logic [1:0]        i_cmd_burst,
  input  logic              i_wd_valid,
  output logic              o_wd_ready,
  input  logic [DATA_W-1:0] i_wd_data,
  input  logic [STRB_W-1:0] i_wd_strb,
  output logic              o_wr_done,
  output logic [ID_W-1:0]   o_wr_id,
  output logic [1:0]        o_wr_resp,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [1:0]        o_rd_resp,
  output logic              o_rd_last,
  output logic [ID_W-1:0]   o_rd_id,
  output logic [ID_W-1:0]   o_awid,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [3:0]        o_awlen,
  output logic [2:0]        o_awsize,
  output logic [1:0]        o_awbrust,
  output logic [1:0]        o_awlock,
  output logic [3:0]        o_awcache,
  output logic [2:0]        o_awprot,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [ID_W-1:0]   o_wid,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrob,
  output logic              o_wlast,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic [ID_W-1:0]   i_bid,
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready,
  output logic [ID_W-1:0]   o_arid,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [3:0]        o_arlen,
  output logic [2:0]        o_arsize,
  output logic [1:0]        o_arbrust,
  output logic [1:0]        o_arlock,
  output logic [3:0]        o_arcache,
  output logic [2:0]        o_arprot,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [ID_W-1:0]   i_rid,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rlast,
  input  logic              i_rvalid,
  output logic              o_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic [ID_W-1:0]   r_awid, r_wid, r_wr_id, r_arid, r_rd_id;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [3:0]        r_awlen, r_arlen, r_wcnt;
  logic [2:0]        r_awsize, r_arsize;
  logic [1:0]        r_awbrust, r_arbrust, r_wr_resp, r_rd_resp;
  logic              r_awvalid, r_arvalid, r_wvalid, r_wlast, r_wloaded;
  logic              r_wr_done, r_rd_valid, r_rd_last;
  logic [DATA_W-1:0] r_wdata, r_rd_data;
  logic [STRB_W-1:0] r_wstrob;

  logic w_cmd_fire, w_wr_accept, w_rd_accept, w_wd_fire, w_r_fire;

  assign w_cmd_fire  = i_cmd_valid & o_cmd_ready;
  assign w_wr_accept = w_cmd_fire & i_cmd_write;
  assign w_rd_accept = w_cmd_fire & ~i_cmd_write;
  assign w_wd_fire   = i_wd_valid & o_wd_ready;
  assign w_r_fire    = i_rvalid & o_rready;

  always_ff @(posedge i_aclk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (w_wr_accept) w_wstate_nxt = W_ADDR;
      W_ADDR: if (r_awvalid && i_awready) w_wstate_nxt = W_DATA;
      W_DATA: if (r_wvalid && i_wready && r_wlast) w_wstate_nxt = W_RESP;
      W_RESP: if (i_bvalid) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_rd_accept) w_rstate_nxt = R_ADDR;
      R_ADDR: if (r_arvalid && i_arready) w_rstate_nxt = R_DATA;
      R_DATA: if (i_rvalid && i_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // cmd_ready is gated by reset so nothing looks ready while arstn is low
  always_comb begin
    o_cmd_ready = i_arstn & (i_cmd_write ? (r_wstate == W_IDLE) : (r_rstate == R_IDLE));
    o_wd_ready  = (r_wstate == W_DATA) & ~r_wloaded & (~r_wvalid | i_wready);
    o_bready    = (r_wstate == W_RESP);
    o_rready    = (r_rstate == R_DATA);
  end

  always_ff @(posedge i_aclk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awbrust <= '0;
      r_awvalid <= 1'b0;
      r_wid     <= '0;
      r_wdata   <= '0;
      r_wstrob  <= '0;
      r_wlast   <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wcnt    <= '0;
      r_wloaded <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_id   <= '0;
      r_wr_resp <= '0;
    end else begin
      r_wr_done <= 1'b0;
      if (w_wr_accept) begin
        r_awid    <= i_cmd_id;
        r_awaddr  <= i_cmd_addr;
        r_awlen   <= i_cmd_len;
        r_awsize  <= i_cmd_size;
        r_awbrust <= i_cmd_burst;
        r_awvalid <= 1'b1;
        r_wid     <= i_cmd_id;
        r_wcnt    <= '0;
        r_wloaded <= 1'b0;
      end else if (r_awvalid && i_awready) begin
        r_awvalid <= 1'b0;
      end
      // A new beat may replace one completing in the same cycle
      if (w_wd_fire) begin
        r_wdata   <= i_wd_data;
        r_wstrob  <= i_wd_strb;
        r_wvalid  <= 1'b1;
        r_wlast   <= (r_wcnt == r_awlen);
        r_wloaded <= (r_wcnt == r_awlen);
        r_wcnt    <= r_wcnt + 4'd1;
      end else if (r_wvalid && i_wready) begin
        r_wvalid  <= 1'b0;
        r_wlast   <= 1'b0;
      end
      if (o_bready && i_bvalid) begin
        r_wr_done <= 1'b1;
        r_wr_id   <= i_bid;
        r_wr_resp <= i_bresp;
      end
    end
  end

  always_ff @(posedge i_aclk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_arid     <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_arbrust  <= '0;
      r_arvalid  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_resp  <= '0;
      r_rd_last  <= 1'b0;
      r_rd_id    <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_rd_accept) begin
        r_arid    <= i_cmd_id;
        r_araddr  <= i_cmd_addr;
        r_arlen   <= i_cmd_len;
        r_arsize  <= i_cmd_size;
        r_arbrust <= i_cmd_burst;
        r_arvalid <= 1'b1;
      end else if (r_arvalid && i_arready) begin
        r_arvalid <= 1'b0;
      end
      if (w_r_fire) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= i_rdata;
        r_rd_resp  <= i_rresp;
        r_rd_last  <= i_rlast;
        r_rd_id    <= i_rid;
      end
    end
  end

  assign o_awid    = r_awid;
  assign o_awaddr  = r_awaddr;
  assign o_awlen   = r_awlen;
  assign o_awsize  = r_awsize;
  assign o_awbrust = r_awbrust;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'b0000;
  assign o_awprot  = 3'b000;
  assign o_awvalid = r_awvalid;
  assign o_wid     = r_wid;
  assign o_wdata   = r_wdata;
  assign o_wstrob  = r_wstrob;
  assign o_wlast   = r_wlast;
  assign o_wvalid  = r_wvalid;
  assign o_wr_done = r_wr_done;
  assign o_wr_id   = r_wr_id;
  assign o_wr_resp = r_wr_resp;
  assign o_arid    = r_arid;
  assign o_araddr  = r_araddr;
  assign o_arlen   = r_arlen;
  assign o_arsize  = r_arsize;
  assign o_arbrust = r_arbrust;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'b0000;
  assign o_arprot  = 3'b000;
  assign o_arvalid = r_arvalid;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_resp  = r_rd_resp;
  assign o_rd_last  = r_rd_last;
  assign o_rd_id    = r_rd_id;

endmodule

// File: tb/tb_axi3_mas_port.sv
// tb/tb_axi3_mas_port.sv - self-checking bench for axi3_mas_port
// AXI slave model at negedge, scoreboard queues filled when stimulus is driven.
module tb_axi3_mas_port;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [3:0]  cmd_id = 0, cmd_len = 0;
  logic [31:0] cmd_addr = 0;
  logic [2:0]  cmd_size = 0;
  logic [1:0]  cmd_burst = 0;
  logic        wd_valid = 0, wd_ready;
  logic [31:0] wd_data = 0;
  logic [3:0]  wd_strb = 0;
  logic        wr_done;
  logic [3:0]  wr_id;
  logic [1:0]  wr_resp;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [3:0]  rd_id;
  logic [3:0]  awid, awlen, awcache, wid, wstrob, arid, arlen, arcache;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awbrust, awlock, arbrust, arlock;
  logic        awvalid, wlast, wvalid, bready, arvalid, rready;
  logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
  logic [3:0]  bid = 0, rid = 0;
  logic [1:0]  bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;

  axi3_mas_port dut (
    .i_aclk(clk), .i_arstn(arstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_id(cmd_id), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_cmd_size(cmd_size), .i_cmd_burst(cmd_burst),
    .i_wd_valid(wd_valid), .o_wd_ready(wd_ready), .i_wd_data(wd_data), .i_wd_strb(wd_strb),
    .o_wr_done(wr_done), .o_wr_id(wr_id), .o_wr_resp(wr_resp),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_resp(rd_resp),
    .o_rd_last(rd_last), .o_rd_id(rd_id),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awbrust(awbrust), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wid(wid), .o_wdata(wdata), .o_wstrob(wstrob), .o_wlast(wlast),
    .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arbrust(arbrust), .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .i_rvalid(rvalid), .o_rready(rready)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [1:0] burst;} addr_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [3:0] strb; logic last;} wbeat_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} done_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;

  addr_t  exp_aw[$], exp_ar[$];
  wbeat_t exp_w[$];
  done_t  exp_done[$];
  rbeat_t exp_r[$];

  int n_tests = 0, n_fail = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // slave model configuration, written only by the main thread
  int          cfg_awdelay = 0, cfg_ardelay = 0, cfg_wmode = 0;
  logic [1:0]  cfg_bresp = 0;
  logic [31:0] cfg_rbase = 0;

  // slave model state, written only by the slave block
  int         aw_wait = 0, ar_wait = 0, r_left = 0, r_idx = 0;
  int         w_beats_seen = 0, rd_seen = 0, wr_done_seen = 0;
  bit         aw_ok = 0, w_last_seen = 0, tog = 0;
  bit         prev_aw_stall = 0, prev_ar_stall = 0, prev_w_stall = 0;
  logic [3:0] aw_id_seen = 0, ar_id_seen = 0;
  logic [40:0] pw_snap = 0;

  always @(negedge clk) begin
    if (!arstn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
      aw_wait = 0; ar_wait = 0; r_left = 0; aw_ok = 0; w_last_seen = 0; tog = 0;
      prev_aw_stall = 0; prev_ar_stall = 0; prev_w_stall = 0;
    end else begin
      if (wr_done) begin
        wr_done_seen++;
        if (exp_done.size() == 0) check("wr_done_unexpected", wr_done, 0);
        else check("wr_done_fields", {wr_id, wr_resp}, exp_done.pop_front());
      end
      if (rd_valid) begin
        rd_seen++;
        if (exp_r.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
        else check("rd_beat", {rd_id, rd_data, rd_resp, rd_last}, exp_r.pop_front());
      end
      // AW
      awready = 0;
      if (prev_aw_stall) check("awvalid_held", awvalid, 1);
      if (awvalid) begin
        check("aw_fixed", {awlock, awcache, awprot}, 0);
        if (aw_wait >= cfg_awdelay) begin
          awready = 1;
          aw_wait = 0;
          aw_ok = 1;
          aw_id_seen = awid;
          if (exp_aw.size() == 0) check("aw_unexpected", awvalid, 0);
          else check("aw_fields", {awid, awaddr, awlen, awsize, awbrust}, exp_aw.pop_front());
        end else aw_wait++;
      end
      prev_aw_stall = awvalid && !awready;
      // W
      if (prev_w_stall) check("w_stable", {wvalid, wid, wdata, wstrob, wlast}, {1'b1, pw_snap});
      case (cfg_wmode)
        0: wready = 1;
        1: begin tog = ~tog; wready = tog; end
        default: wready = 0;
      endcase
      if (wvalid) begin
        check("w_after_aw", aw_ok, 1);
        if (wready) begin
          w_beats_seen++;
          if (wlast) w_last_seen = 1;
          if (exp_w.size() == 0) check("w_unexpected", wvalid, 0);
          else check("w_beat", {wid, wdata, wstrob, wlast}, exp_w.pop_front());
        end
      end
      prev_w_stall = wvalid && !wready;
      pw_snap = {wid, wdata, wstrob, wlast};
      // B
      if (bready && !bvalid && w_last_seen) begin
        bvalid = 1; bid = aw_id_seen; bresp = cfg_bresp;
        w_last_seen = 0; aw_ok = 0;
      end else bvalid = 0;
      // R data generator, one beat per cycle while rready
      if (rready && r_left > 0) begin
        rvalid = 1; rdata = cfg_rbase + r_idx; rresp = 2'(r_idx); rid = ar_id_seen;
        rlast = (r_left == 1);
        exp_r.push_back({rid, rdata, rresp, rlast});
        r_left--; r_idx++;
      end else begin
        rvalid = 0; rlast = 0;
      end
      // AR
      arready = 0;
      if (prev_ar_stall) check("arvalid_held", arvalid, 1);
      if (arvalid) begin
        check("ar_fixed", {arlock, arcache, arprot}, 0);
        if (ar_wait >= cfg_ardelay) begin
          arready = 1;
          ar_wait = 0;
          ar_id_seen = arid;
          r_left = int'(arlen) + 1;
          r_idx = 0;
          if (exp_ar.size() == 0) check("ar_unexpected", arvalid, 0);
          else check("ar_fields", {arid, araddr, arlen, arsize, arbrust}, exp_ar.pop_front());
        end else ar_wait++;
      end
      prev_ar_stall = arvalid && !arready;
    end
  end

  task automatic issue_cmd(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] resp);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
    cmd_len = len; cmd_size = size; cmd_burst = burst;
    if (wr) begin
      exp_aw.push_back({id, addr, len, size, burst});
      exp_done.push_back({id, resp});
    end else exp_ar.push_back({id, addr, len, size, burst});
    #1;
    while (!cmd_ready && t < 50) begin @(negedge clk); #1; t++; end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic send_wd(input logic [3:0] id, input logic [3:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      int t;
      d = $urandom;
      s = 4'($urandom);
      t = 0;
      wd_valid = 1; wd_data = d; wd_strb = s;
      #1;
      while (!wd_ready && t < 200) begin @(negedge clk); #1; t++; end
      check("wd_accept", wd_ready, 1);
      exp_w.push_back({id, d, s, (i == int'(len))});
      @(negedge clk);
    end
    wd_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while ((exp_aw.size() + exp_ar.size() + exp_w.size() + exp_done.size() + exp_r.size() != 0
            || r_left != 0) && t < bound) begin
      @(negedge clk); #1; t++;
    end
    check("idle_timeout", (t >= bound), 0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    bit wr; logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size;
    logic [1:0] burst; int delay; int wmode; logic [1:0] bresp; logic [31:0] rbase;
    int exp_beats;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, t;
    vecs[0] = '{1, 4'h5, 32'h0000_1000, 4'd3,  3'd2, 2'd1, 2, 0, 2'b00, 32'h0,   4};
    vecs[1] = '{1, 4'h2, 32'h0000_1234, 4'd0,  3'd2, 2'd1, 0, 1, 2'b10, 32'h0,   1};
    vecs[2] = '{0, 4'h3, 32'h0000_2000, 4'd7,  3'd2, 2'd1, 1, 0, 2'b00, 32'h0,   8};
    vecs[3] = '{1, 4'hF, 32'hFFFF_FFFC, 4'd15, 3'd1, 2'd2, 0, 1, 2'b01, 32'h0,   16};
    vecs[4] = '{0, 4'h0, 32'h0000_0040, 4'd0,  3'd0, 2'd0, 3, 0, 2'b00, 32'd100, 1};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready, cmd_ready, wd_ready, wr_done, rd_valid}, 0);
    check("rst_payload", {awaddr, araddr}, 0);
    arstn = 1;
    @(negedge clk);

    foreach (vecs[k]) begin
      cfg_awdelay = vecs[k].delay; cfg_ardelay = vecs[k].delay; cfg_wmode = vecs[k].wmode;
      cfg_bresp = vecs[k].bresp; cfg_rbase = vecs[k].rbase;
      wb = w_beats_seen; rb = rd_seen;
      issue_cmd(vecs[k].wr, vecs[k].id, vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].bresp);
      if (vecs[k].wr) send_wd(vecs[k].id, vecs[k].len);
      wait_idle(400);
      if (vecs[k].wr) check($sformatf("w_beats_v%0d", k), w_beats_seen - wb, vecs[k].exp_beats);
      else begin
        check($sformatf("r_beats_v%0d", k), rd_seen - rb, vecs[k].exp_beats);
        check($sformatf("rready_low_v%0d", k), rready, 0);
      end
    end

    // concurrent write and read
    cfg_awdelay = 1; cfg_ardelay = 0; cfg_wmode = 0; cfg_bresp = 2'b01; cfg_rbase = 32'h100;
    wb = w_beats_seen; rb = rd_seen; t = wr_done_seen;
    issue_cmd(1, 4'h6, 32'h0000_4000, 4'd1, 3'd2, 2'd1, 2'b01);
    cmd_write = 1; #1;
    check("cmd_ready_wr_busy", cmd_ready, 0);
    cmd_write = 0; #1;
    check("cmd_ready_rd_free", cmd_ready, 1);
    issue_cmd(0, 4'hA, 32'h0000_5000, 4'd1, 3'd2, 2'd1, 2'b00);
    send_wd(4'h6, 4'd1);
    wait_idle(400);
    check("conc_w_beats", w_beats_seen - wb, 2);
    check("conc_r_beats", rd_seen - rb, 2);
    check("conc_wr_done", wr_done_seen - t, 1);

    // reset in the middle of W_DATA with the W channel stalled
    cfg_awdelay = 0; cfg_wmode = 2;
    issue_cmd(1, 4'h9, 32'h0000_3000, 4'd3, 3'd2, 2'd1, 2'b00);
    wd_valid = 1; wd_data = 32'hDEAD_BEEF; wd_strb = 4'hF;
    t = 0;
    #1;
    while (!wd_ready && t < 50) begin @(negedge clk); #1; t++; end
    check("rst_wd_accept", wd_ready, 1);
    @(negedge clk);
    wd_valid = 0;
    repeat (2) @(negedge clk);
    check("stall_wvalid", wvalid, 1);
    #2 arstn = 0;
    #1;
    check("mid_rst_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready, cmd_ready, wd_ready, wr_done, rd_valid}, 0);
    check("mid_rst_payload", {wdata, awaddr}, 0);
    check("mid_rst_ids", {awid, wid, awlen, wstrob}, 0);
    exp_aw.delete(); exp_w.delete(); exp_done.delete();
    repeat (3) @(negedge clk);
    arstn = 1;
    cfg_wmode = 0;
    t = wr_done_seen;
    repeat (10) @(negedge clk);
    check("no_wr_done_after_rst", wr_done_seen - t, 0);
    cmd_write = 1; #1;
    check("w_idle_after_rst", cmd_ready, 1);
    cmd_write = 0; #1;
    check("r_idle_after_rst", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
